// File: rtl/m_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : m_ifetch
//  Description : Instruction fetch stage with a prefetch queue. Owns the PC,
//                drives the word address to a combinational instruction
//                memory, buffers {pc, inst} pairs in a DEPTH-entry FIFO and
//                hands them to decode through a valid/ready handshake.
//                A redirect flushes the queue and reloads the PC.
//  Ports       : w_clk / w_rst        clock, async active-high reset
//                w_imem_adr           fetch address (= current PC)
//                w_imem_inst          instruction word for w_imem_adr
//                w_redirect(_pc)      flush + new PC (low two bits dropped)
//                w_out_valid/ready    decode handshake
//                w_out_pc/inst        head entry, zero when queue empty
//                w_count              queue occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module m_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  output logic [31:0]              w_imem_adr,
  input  logic [31:0]              w_imem_inst,
  input  logic                     w_redirect,
  input  logic [31:0]              w_redirect_pc,
  output logic                     w_out_valid,
  input  logic                     w_out_ready,
  output logic [31:0]              w_out_pc,
  output logic [31:0]              w_out_inst,
  output logic [$clog2(DEPTH):0]   w_count
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [31:0]     r_pc;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;

  // Entry storage holds data only; it is qualified by r_count, so no reset.
  logic [31:0]     r_ent_pc   [DEPTH];
  logic [31:0]     r_ent_inst [DEPTH];

  logic            w_deq;
  logic            w_enq;
  logic            w_unused_redirect_lsbs;

  // Redirect targets are word aligned; the low bits are intentionally ignored.
  assign w_unused_redirect_lsbs = ^w_redirect_pc[1:0];

  // All outputs derive from registered state: no path from w_imem_inst or
  // w_out_ready to the decode-facing outputs.
  assign w_out_valid = (r_count != '0);
  assign w_out_pc    = w_out_valid ? r_ent_pc[r_rd_ptr]   : 32'h0;
  assign w_out_inst  = w_out_valid ? r_ent_inst[r_rd_ptr] : 32'h0;
  assign w_count     = r_count;
  assign w_imem_adr  = r_pc;

  assign w_deq = w_out_valid & w_out_ready;
  // A full queue can still accept a fetch when the head leaves the same edge;
  // the write lands in the slot being vacated by the read.
  assign w_enq = ~w_redirect & ((r_count < c_FULL) | w_deq);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      // Head accepted this cycle (if any) is consumed by decode; everything
      // else is dropped.
      r_pc     <= {w_redirect_pc[31:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_enq & ~w_deq) begin
        r_count <= r_count + c_CW'(1);
      end else if (~w_enq & w_deq) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_enq) begin
      r_ent_pc[r_wr_ptr]   <= r_pc;
      r_ent_inst[r_wr_ptr] <= w_imem_inst;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_ifetch
//  Description : Self-checking bench for m_ifetch. Directed vector table,
//                hand-written async-reset sequence, and a randomized phase
//                compared against a queue-based reference model. A second
//                instance with a wrapping reset PC runs alongside with decode
//                always ready.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_ifetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] PC2_RESET = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, inst, rpc, out_pc, out_inst;
  logic        redir, valid, ready;
  logic [2:0]  cnt;

  logic [31:0] adr2, inst2, out_pc2, out_inst2;
  logic        valid2;
  logic [2:0]  cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign inst  = imem(adr);
  assign inst2 = imem(adr2);

  m_ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .w_clk(clk), .w_rst(rst), .w_imem_adr(adr), .w_imem_inst(inst),
    .w_redirect(redir), .w_redirect_pc(rpc), .w_out_valid(valid),
    .w_out_ready(ready), .w_out_pc(out_pc), .w_out_inst(out_inst),
    .w_count(cnt));

  m_ifetch #(.DEPTH(DEPTH), .RESET_PC(PC2_RESET)) dut2 (
    .w_clk(clk), .w_rst(rst), .w_imem_adr(adr2), .w_imem_inst(inst2),
    .w_redirect(1'b0), .w_redirect_pc(32'h0), .w_out_valid(valid2),
    .w_out_ready(1'b1), .w_out_pc(out_pc2), .w_out_inst(out_inst2),
    .w_count(cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the always-ready wrap instance ----
  logic [31:0] m2_q[$];
  logic [31:0] m2_pc;

  task automatic m2_reset();
    m2_q.delete();
    m2_pc = PC2_RESET;
  endtask

  // ---------------- reference model for the main instance -----------------
  logic [31:0] m1_q[$];
  logic [31:0] m1_pc;

  task automatic m1_reset();
    m1_q.delete();
    m1_pc = 32'h0;
  endtask

  task automatic m1_check();
    logic [31:0] hd;
    hd = (m1_q.size() > 0) ? m1_q[0] : 32'h0;
    chk("rnd_valid", {31'b0, valid}, {31'b0, (m1_q.size() > 0)});
    chk("rnd_count", {29'b0, cnt}, 32'(m1_q.size()));
    chk("rnd_pc", out_pc, hd);
    chk("rnd_inst", out_inst, (m1_q.size() > 0) ? imem(hd) : 32'h0);
    chk("rnd_adr", adr, m1_pc);
  endtask

  task automatic m1_update();
    int  sz;
    bit  deq;
    sz  = m1_q.size();
    deq = (sz > 0) && ready;
    if (redir) begin
      m1_q.delete();
      m1_pc = {rpc[31:2], 2'b00};
    end else begin
      if (deq) void'(m1_q.pop_front());
      if (sz < DEPTH || deq) begin
        m1_q.push_back(m1_pc);
        m1_pc = m1_pc + 32'd4;
      end
    end
  endtask

  // One clock: check the wrap instance against its model, advance the
  // model, then step past the edge.
  task automatic tick();
    chk("wrap_valid", {31'b0, valid2}, {31'b0, (m2_q.size() > 0)});
    chk("wrap_pc", out_pc2, (m2_q.size() > 0) ? m2_q[0] : 32'h0);
    chk("wrap_inst", out_inst2, (m2_q.size() > 0) ? imem(m2_q[0]) : 32'h0);
    chk("wrap_adr", adr2, m2_pc);
    if (m2_q.size() > 0) void'(m2_q.pop_front());
    m2_q.push_back(m2_pc);
    m2_pc = m2_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  // Short async reset pulse between edges, with immediate output checks.
  task automatic do_reset();
    rst = 1'b1;
    m2_reset();
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_count", {29'b0, cnt}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_adr", adr, 32'h0);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [31:0] exp_pc;
    logic [31:0] exp_adr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic rr, input logic [31:0] p,
                     input logic v, input logic [2:0] c, input logic [31:0] pc,
                     input logic [31:0] a);
    vec_t t;
    t = '{rst: r, ready: rd, redir: rr, rpc: p, exp_valid: v, exp_count: c,
          exp_pc: pc, exp_adr: a};
    vecs.push_back(t);
  endtask

  initial begin
    ready = 1'b0;
    redir = 1'b0;
    rpc   = 32'h0;
    m2_reset();
    m1_reset();

    // Startup, always ready (vectors 0..3 also watch the wrap instance)
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'h0,  32'h4);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'h4,  32'h8);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'h8,  32'hC);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'hC,  32'h10);
    // Backpressure fill, then full with simultaneous deq/enq, then drain
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 32'h0,  32'h4);
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd2, 32'h0,  32'h8);
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd3, 32'h0,  32'hC);
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h0,  32'h10);
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h0,  32'h10);
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h0,  32'h10);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h4,  32'h14);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h8,  32'h18);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'hC,  32'h1C);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h10, 32'h20);
    // Redirect with three entries queued, unaligned target
    add(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 3'd1, 32'h0,   32'h4);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd2, 32'h0,   32'h8);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd3, 32'h0,   32'hC);
    add(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 3'd0, 32'h0,   32'h40);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd1, 32'h40,  32'h44);
    // Redirect while the head is being accepted
    add(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 3'd0, 32'h0,   32'h100);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 32'h100, 32'h104);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 32'h104, 32'h108);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      ready = vecs[i].ready;
      redir = vecs[i].redir;
      rpc   = vecs[i].rpc;
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_count", i), {29'b0, cnt}, {29'b0, vecs[i].exp_count});
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_inst", i), out_inst,
          vecs[i].exp_valid ? imem(vecs[i].exp_pc) : 32'h0);
      chk($sformatf("v%0d_adr", i), adr, vecs[i].exp_adr);
      if (i < 4) chk($sformatf("wrap_seq%0d", i), out_pc2, PC2_RESET + 32'(i) * 32'd4);
    end
    redir = 1'b0;

    // Async reset mid-stream with two entries queued
    do_reset();
    ready = 1'b0;
    tick();
    tick();
    chk("mid_count_pre", {29'b0, cnt}, 32'd2);
    #2;
    rst = 1'b1;
    m2_reset();
    #1;
    chk("mid_valid", {31'b0, valid}, 32'h0);
    chk("mid_count", {29'b0, cnt}, 32'h0);
    chk("mid_pc", out_pc, 32'h0);
    chk("mid_adr", adr, 32'h0);
    chk("mid_wrap_adr", adr2, PC2_RESET);
    #2;
    rst = 1'b0;
    tick();
    chk("mid_after_count", {29'b0, cnt}, 32'd1);
    chk("mid_after_pc", out_pc, 32'h0);

    // Randomized traffic against the queue model
    do_reset();
    m1_reset();
    for (int c = 0; c < 600; c++) begin
      if (((c / 60) % 2) == 0) ready = ($urandom_range(0, 3) != 0);
      else                     ready = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      m1_check();
      m1_update();
      tick();
    end
    redir = 1'b0;
    m1_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_ifetch.md
# m_ifetch

Instruction fetch stage with a prefetch queue, sitting directly upstream of the processor's decode/register-file stage. It owns the program counter, drives the word address into the combinational instruction memory, and buffers fetched {pc, instruction} pairs in a small FIFO. It presents them to decode through a valid/ready handshake and flushes on a redirect (branch/jump) request.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, minimum 2
- RESET_PC, 32'h0, PC value loaded on reset
- w_clk  input  1  clock, all state updates on rising edge
- w_rst  input  1  reset, asynchronous, active-high
- w_imem_adr  output  32  fetch address, always equal to internal r_pc
- w_imem_inst  input  32  instruction word returned combinationally for w_imem_adr
- w_redirect  input  1  flush queue and load new PC this edge
- w_redirect_pc  input  32  redirect target; bits [1:0] forced to 0 on load
- w_out_valid  output  1  head entry available to decode
- w_out_ready  input  1  decode accepts head entry this cycle
- w_out_pc  output  32  PC of head entry; 0 when queue empty
- w_out_inst  output  32  instruction of head entry; 0 when queue empty
- w_count  output  $clog2(DEPTH)+1  current queue occupancy

## Operation
- State: r_pc, DEPTH-entry storage of {pc, inst}, read pointer, write pointer ($clog2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter.
- Dequeue (deq) = w_out_valid & w_out_ready; read pointer advances, count decrements.
- Enqueue (enq) = !w_redirect & (count < DEPTH | deq). Stores {r_pc, w_imem_inst} at write pointer; write pointer advances; r_pc <= r_pc + 4.
- Full with simultaneous dequeue: enqueue permitted; count stays DEPTH.
- Full without dequeue: no enqueue, r_pc holds, w_imem_adr stable.
- enq & deq same cycle: count unchanged.
- Redirect (highest priority): count, both pointers cleared to 0; r_pc <= {w_redirect_pc[31:2], 2'b00}; nothing enqueued. A head entry presented with valid & ready in the redirect cycle counts as accepted by decode; all other entries are discarded.
- w_out_valid = (count != 0). w_out_pc / w_out_inst show the head entry when valid, else 32'h0.
- PC arithmetic is 32-bit unsigned, wraps: 32'hFFFF_FFFC + 4 = 32'h0.
- Entry storage contents need no reset; only control state is reset.

## Timing
- Reset (asserted, asynchronous, takes effect immediately without a clock edge): r_pc = RESET_PC, w_imem_adr = RESET_PC, count = 0, w_out_valid = 0, w_out_pc = 0, w_out_inst = 0, w_count = 0. Reset mid-operation discards all queued entries at once.
- First edge after reset release enqueues RESET_PC; w_out_valid = 1 from the following cycle.
- Fetch-to-decode latency: 1 cycle. An instruction fetched at edge N is visible on the outputs after edge N, with no combinational bypass from w_imem_inst to w_out_*.
- Throughput: 1 entry per cycle when decode is always ready; steady-state count = 1.
- Redirect latency: target enqueued on the edge after the redirect edge; visible on the outputs one cycle later. The minimum bubble is 1 cycle of w_out_valid = 0.
- w_out_valid must not depend combinationally on w_out_ready. Outputs are functions of registered state only.

## Test plan
- Reset/startup: imem[k] = 32'h1000_0000 + k, ready = 1, release reset -> cycle 1 outputs pc 0 / inst 32'h1000_0000, then pc 4, 8, 12 on consecutive cycles; count = 1 steady.
- Backpressure fill: ready = 0 for 6 cycles after reset -> count goes 1,2,3,4,4,4; w_imem_adr frozen at 16; raise ready -> pcs 0,4,8,12,16 drained in order without gaps or duplicates.
- Full + simultaneous deq/enq: queue full (count 4), ready = 1 for one cycle -> count stays 4, pc 16 enqueued, head becomes pc 4.
- Redirect with queued entries: count = 3, pulse redirect with w_redirect_pc = 32'h0000_0043 -> next cycle count 0, valid 0, w_imem_adr = 32'h40; following cycle head pc = 32'h40.
- Wrap-around: RESET_PC = 32'hFFFF_FFF8, ready = 1 -> output pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004; FIFO pointers wrap past DEPTH entries with no corruption over 20 cycles.
- Async reset mid-stream: assert w_rst between clock edges while count = 2 -> w_out_valid, w_count, w_out_pc fall to 0 immediately; w_imem_adr = RESET_PC before the next edge.
